// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: ARM condition check, CPSR flag update and 2-entry writeback buffer.
// Optional WB_STATS_EN adds saturating executed/squashed instruction counters.
module alu_writeback_stage #(
  parameter int DEPTH = 2,
  parameter int RD_W  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_result,
  input  logic            in_nf,
  input  logic            in_zf,
  input  logic            in_cf,
  input  logic            in_vf,
  input  logic [4:0]      in_op,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_s,
  input  logic [3:0]      in_cond,
  input  logic            msr_we,
  input  logic [3:0]      msr_nzcv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic [3:0]      cpsr_nzcv,
  output logic            cond_pass
`ifdef WB_STATS_EN
  ,
  output logic [15:0]     exec_cnt,
  output logic [15:0]     squash_cnt
`endif
);
  logic [1:0]      r_count;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [3:0]      r_cpsr;
  logic [31:0]     r_res [DEPTH];
  logic [RD_W-1:0] r_rd [DEPTH];
  logic            w_n, w_z, w_c, w_v;
  logic            w_cond;
  logic            w_is_log, w_is_cmp;
  logic            w_acc, w_exec, w_push, w_pop;
  logic [3:0]      w_nzcv;
  assign {w_n, w_z, w_c, w_v} = r_cpsr;
  always_comb begin
    w_cond = 1'b0;
    case (in_cond)
      4'h0: w_cond = w_z;
      4'h1: w_cond = !w_z;
      4'h2: w_cond = w_c;
      4'h3: w_cond = !w_c;
      4'h4: w_cond = w_n;
      4'h5: w_cond = !w_n;
      4'h6: w_cond = w_v;
      4'h7: w_cond = !w_v;
      4'h8: w_cond = w_c & !w_z;
      4'h9: w_cond = !w_c | w_z;
      4'hA: w_cond = w_n == w_v;
      4'hB: w_cond = w_n != w_v;
      4'hC: w_cond = !w_z & (w_n == w_v);
      4'hD: w_cond = w_z | (w_n != w_v);
      4'hE: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end
  assign cond_pass = w_cond;
  assign w_is_log  = in_op inside {5'b00000, 5'b00001, 5'b01100, 5'b01101, 5'b01110, 5'b01111};
  assign w_is_cmp  = in_op inside {5'b01000, 5'b01001, 5'b01010, 5'b01011};
  assign in_ready  = r_count < 2'(DEPTH);
  assign out_valid = r_count != 2'd0;
  assign w_acc     = in_valid & in_ready;
  assign w_exec    = w_acc & w_cond;
  assign w_push    = w_exec & !w_is_cmp;
  assign w_pop     = out_valid & out_ready;
  // MSR wins over any flag update from the instruction accepted in the same cycle
  always_comb begin
    w_nzcv = r_cpsr;
    if (msr_we)
      w_nzcv = msr_nzcv;
    else if (w_exec & w_is_cmp)
      w_nzcv = in_op[1] ? {in_nf, in_zf, in_cf, in_vf} : {in_nf, in_zf, r_cpsr[1:0]};
    else if (w_exec & in_s)
      w_nzcv = w_is_log ? {in_nf, in_zf, r_cpsr[1:0]} : {in_nf, in_zf, in_cf, in_vf};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cpsr   <= '0;
      r_res    <= '{default: '0};
      r_rd     <= '{default: '0};
    end else begin
      r_cpsr  <= w_nzcv;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
      if (w_push) begin
        r_res[r_wr_ptr] <= in_result;
        r_rd[r_wr_ptr]  <= in_rd;
        r_wr_ptr        <= !r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= !r_rd_ptr;
    end
  end
  assign out_result = r_res[r_rd_ptr];
  assign out_rd     = r_rd[r_rd_ptr];
  assign cpsr_nzcv  = r_cpsr;
`ifdef WB_STATS_EN
  logic [15:0] r_exec_cnt, r_squash_cnt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_exec_cnt   <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (w_exec && r_exec_cnt != 16'hFFFF)
        r_exec_cnt <= r_exec_cnt + 16'd1;
      if (w_acc && !w_cond && r_squash_cnt != 16'hFFFF)
        r_squash_cnt <= r_squash_cnt + 16'd1;
    end
  end
  assign exec_cnt   = r_exec_cnt;
  assign squash_cnt = r_squash_cnt;
`endif
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: scoreboard bench with directed scenarios and randomized traffic.
module tb_alu_writeback_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_nf = 1'b0, in_zf = 1'b0, in_cf = 1'b0, in_vf = 1'b0;
  logic [4:0]  in_op = '0;
  logic [3:0]  in_rd = '0;
  logic        in_s = 1'b0;
  logic [3:0]  in_cond = 4'hE;
  logic        msr_we = 1'b0;
  logic [3:0]  msr_nzcv = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic [3:0]  cpsr_nzcv;
  logic        cond_pass;
`ifdef WB_STATS_EN
  logic [15:0] exec_cnt, squash_cnt;
`endif

  alu_writeback_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_nf(in_nf), .in_zf(in_zf), .in_cf(in_cf), .in_vf(in_vf),
    .in_op(in_op), .in_rd(in_rd), .in_s(in_s), .in_cond(in_cond),
    .msr_we(msr_we), .msr_nzcv(msr_nzcv), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .cpsr_nzcv(cpsr_nzcv), .cond_pass(cond_pass)
`ifdef WB_STATS_EN
    , .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit m_live = 0;
  logic [3:0] m_cpsr;
  int m_cnt;
  int m_exec, m_squash;
  logic [35:0] expq[$];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      0: return z;           1: return !z;
      2: return cy;          3: return !cy;
      4: return n;           5: return !n;
      6: return v;           7: return !v;
      8: return cy && !z;    9: return !cy || z;
      10: return n == v;     11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // Reference model: advances at each edge from the inputs presented during the cycle
  always @(posedge clk) begin
    if (!reset_n) begin
      m_cpsr = '0; m_cnt = 0; m_exec = 0; m_squash = 0;
      expq.delete();
      m_live = 1;
    end else if (m_live) begin
      bit acc, pass, pop, push;
      pass = cond_ok(in_cond, m_cpsr);
      acc  = in_valid && m_cnt < 2;
      pop  = m_cnt > 0 && out_ready;
      push = 0;
      if (acc && pass) begin
        if (in_op >= 5'd8 && in_op <= 5'd11) begin
          m_cpsr[3:2] = {in_nf, in_zf};
          if (in_op >= 5'd10) m_cpsr[1:0] = {in_cf, in_vf};
        end else begin
          push = 1;
          if (in_s) begin
            if (in_op <= 5'd1 || (in_op >= 5'd12 && in_op <= 5'd15)) m_cpsr[3:2] = {in_nf, in_zf};
            else m_cpsr = {in_nf, in_zf, in_cf, in_vf};
          end
        end
        if (m_exec < 65535) m_exec++;
      end else if (acc && m_squash < 65535) m_squash++;
      if (msr_we) m_cpsr = msr_nzcv;
      if (push) expq.push_back({in_result, in_rd});
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
  end

  // Monitor: compares visible DUT state against the model between edges
  always @(negedge clk) begin
    if (m_live) begin
      chk("cpsr", cpsr_nzcv, m_cpsr);
      chk("in_ready", in_ready, m_cnt < 2);
      chk("out_valid", out_valid, m_cnt != 0);
      chk("cond_pass", cond_pass, cond_ok(in_cond, m_cpsr));
`ifdef WB_STATS_EN
      chk("exec_cnt", exec_cnt, m_exec);
      chk("squash_cnt", squash_cnt, m_squash);
`endif
      if (out_valid && expq.size() > 0) begin
        chk("head", {out_result, out_rd}, expq[0]);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [4:0] op, logic [31:0] res, logic [3:0] rd, logic s,
                      logic [3:0] cond, logic [3:0] nzcv);
    int t = 0;
    in_op = op; in_result = res; in_rd = rd; in_s = s; in_cond = cond;
    {in_nf, in_zf, in_cf, in_vf} = nzcv;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      cyc();
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    // ADD with Z,C set
    send(5'b00100, 32'd0, 4'd3, 1'b1, 4'hE, 4'b0110);
    chk("t1_cpsr", cpsr_nzcv, 4'b0110);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_result", out_result, 32'd0);
    cyc();
    // CMP sets N, then EQ instruction squashed
    send(5'b01010, 32'd5, 4'd1, 1'b0, 4'hE, 4'b1000);
    chk("t2_cpsr", cpsr_nzcv, 4'b1000);
    chk("t2_nopush", out_valid, 1'b0);
    send(5'b00100, 32'd7, 4'd2, 1'b1, 4'h0, 4'b0100);
    chk("t2_squash_cpsr", cpsr_nzcv, 4'b1000);
    chk("t2_squash_nopush", out_valid, 1'b0);
    // Backpressure: three MOVs with out_ready low
    out_ready = 1'b0;
    fork
      begin
        send(5'b01101, 32'd1, 4'd1, 1'b0, 4'hE, 4'b0000);
        send(5'b01101, 32'd2, 4'd2, 1'b0, 4'hE, 4'b0000);
        send(5'b01101, 32'd3, 4'd3, 1'b0, 4'hE, 4'b0000);
      end
      begin
        repeat (6) cyc();
        chk("t3_full", in_ready, 1'b0);
        out_ready = 1'b1;
      end
    join
    repeat (4) cyc();
    // Logical op keeps C,V
    msr_nzcv = 4'b0011; msr_we = 1'b1;
    cyc();
    msr_we = 1'b0;
    send(5'b00000, 32'h10, 4'd5, 1'b1, 4'hE, 4'b1000);
    chk("t4_cpsr", cpsr_nzcv, 4'b1011);
    // MSR overrides same-cycle SUB flags, push still happens
    msr_nzcv = 4'b0101; msr_we = 1'b1;
    send(5'b00010, 32'h55, 4'd4, 1'b1, 4'hE, 4'b1000);
    msr_we = 1'b0;
    chk("t5_cpsr", cpsr_nzcv, 4'b0101);
    chk("t5_push", out_valid, 1'b1);
    chk("t5_result", out_result, 32'h55);
    cyc();
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = $urandom_range(0, 9) < 7;
      in_op     = 5'($urandom);
      in_result = $urandom;
      in_rd     = 4'($urandom);
      in_s      = 1'($urandom);
      in_cond   = 4'($urandom);
      {in_nf, in_zf, in_cf, in_vf} = 4'($urandom);
      msr_we    = $urandom_range(0, 9) == 0;
      msr_nzcv  = 4'($urandom);
      out_ready = $urandom_range(0, 9) < 6;
      cyc();
    end
    in_valid = 1'b0; msr_we = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    // Reset with a full buffer
    out_ready = 1'b0;
    send(5'b01101, 32'hA, 4'd6, 1'b0, 4'hE, 4'b0000);
    send(5'b01101, 32'hB, 4'd7, 1'b0, 4'hE, 4'b0000);
    chk("t6_full", in_ready, 1'b0);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_ready", in_ready, 1'b1);
    chk("t6_cpsr", cpsr_nzcv, 4'b0000);
    chk("t6_result", out_result, 32'd0);
    chk("t6_rd", out_rd, 4'd0);
`ifdef WB_STATS_EN
    chk("t6_exec", exec_cnt, 16'd0);
    chk("t6_squash", squash_cnt, 16'd0);
`endif
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the ARM ALU.
- Accepts each ALU result with its NZCV flags, opcode, destination register, S bit and condition field.
- Evaluates the ARM condition code against the committed CPSR flags and updates the flags per opcode class.
- Queues register-file writebacks in a 2-entry buffer with valid/ready handshakes on both sides.

Parameters:
DEPTH, 2, writeback buffer entries; fixed at 2, pointers are 1 bit.
RD_W, 4, destination register index width.

Ports:
clk  input  1  single clock, rising edge.
reset_n  input  1  synchronous, active-low reset.
in_valid  input  1  upstream ALU result valid.
in_ready  output  1  stage can accept; registered function of buffer count only.
in_result  input  32  ALU R.
in_nf, in_zf, in_cf, in_vf  input  1 each  ALU flags.
in_op  input  5  ALU opcode, same encoding as the ALU.
in_rd  input  RD_W  destination register.
in_s  input  1  S bit (set flags).
in_cond  input  4  ARM condition field.
msr_we  input  1  direct flag write (MSR).
msr_nzcv  input  4  value for MSR, bit order N,Z,C,V.
out_valid  output  1  buffer head valid.
out_ready  input  1  register file accepts head.
out_result  output  32  head result.
out_rd  output  RD_W  head destination.
cpsr_nzcv  output  4  committed flags, registered.
cond_pass  output  1  combinational; in_cond evaluated against cpsr_nzcv.

Behaviour:
- Reset (reset_n low at a clk edge):
  - count=0, wr_ptr=rd_ptr=0, cpsr_nzcv=4'b0000.
  - out_valid=0, in_ready=1, out_result=0, out_rd=0.
  - Reset mid-transfer discards all buffered entries.
- Accept: in_valid & in_ready at a rising edge. At most one accept per cycle.
- in_ready = (count < 2). It never depends on out_ready in the same cycle.
- Conditions, evaluated on cpsr_nzcv:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) always passes; 1111 never passes.
- Accept with cond_pass=0: instruction is consumed; no flag update, no buffer push.
- Accept with cond_pass=1, by opcode class:
  - Logical (AND 00000, EOR 00001, ORR 01100, MOV 01101, BIC 01110, MVN 01111): if in_s, N,Z <= in_nf,in_zf; C,V retained. Push {in_result,in_rd}.
  - Arithmetic (00010..00111, and 1xxxx): if in_s, NZCV <= in_nf,in_zf,in_cf,in_vf. Push.
  - Compare (TST 01000, TEQ 01001: N,Z only; CMP 01010, CMN 01011: all four): flags update regardless of in_s. No push.
- Flag update lands at the accept edge, so it is visible to cond_pass of the next cycle's input. Back-to-back dependent instructions need no stall.
- msr_we=1: cpsr_nzcv <= msr_nzcv at the edge. It overrides any same-cycle instruction flag update. The instruction is still accepted and its push still occurs.
- Drain: out_valid = (count != 0). Pop on out_valid & out_ready; rd_ptr toggles.
- out_result and out_rd show the head entry. They are stable while out_valid & !out_ready.
- Simultaneous push and pop (count=1): count stays 1 and pointers both advance.
- Push and pop at count=0: not allowed (out_valid=0), so count becomes 1.
- Full (count=2): in_ready=0. A pop that cycle drops count to 1, and in_ready rises on the following cycle.
- Latency: an accepted pushing instruction is at the head after one edge (out_valid next cycle when the buffer was empty).

Optional Feature:
- Macro WB_STATS_EN.
- When defined, add output ports exec_cnt[15:0] and squash_cnt[15:0]:
  - exec_cnt counts accepts with cond_pass=1.
  - squash_cnt counts accepts with cond_pass=0.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then ADD (00100), in_s=1, in_result=0, flags Z=1 C=1, cond=1110 -> next cycle cpsr_nzcv=0110; out_valid=1, out_result=0.
- CMP (01010), in_s=0, flags N=1, cond AL; next instr cond=0000 (EQ) -> CMP pushes nothing; cpsr_nzcv=1000; EQ instr squashed, no push.
- Hold out_ready=0 and send 3 MOV instrs (results 1,2,3) -> in_ready=0 after the 2nd accept. Release out_ready -> out_result sequence 1,2,3; count never exceeds 2.
- cpsr_nzcv=0011, logical AND with in_s=1 and flags N=1 Z=0 -> cpsr_nzcv=1011 (C,V retained).
- Same cycle: msr_we=1 with msr_nzcv=0101, plus SUB with in_s=1 and flags 1000 -> cpsr_nzcv=0101; SUB result still pushed.
- Fill buffer, assert reset_n=0 for one edge -> out_valid=0, in_ready=1, cpsr_nzcv=0000. With WB_STATS_EN defined, the counters read 0.
